registro_deslocamento: RTL and testbench
========================================

# registro_deslocamento

Parametrised multi-mode register: the successor to the single-bit storage flip-flop used throughout the controller datapath. Holds a WIDTH-bit word with hold, parallel load, shift-left and shift-right modes, serial in/out, a synchronous clear, and a shift counter that flags when a full word has been shifted since the last load. It serves as the serial/parallel converter and staging register for sensor and actuator words in the control datapath.

## Interface
Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2
- RESET_VALUE, 0, value loaded into Q on RESET; WIDTH bits wide

Derived: CW = $clog2(WIDTH+1), the counter width.

Ports:
- CLOCK  input  1  single clock; all state updates on its rising edge
- RESET  input  1  asynchronous, active-high reset
- ENABLE  input  1  when 0, the register and counter hold; CLEAR still acts
- CLEAR  input  1  synchronous clear
- MODE  input  2  00 hold, 01 parallel load, 10 shift left, 11 shift right
- D  input  WIDTH  parallel load data
- SIN  input  1  serial input bit for shift modes
- ROTATE  input  1  rotate select for shift modes; used only when ROTATE_EN is defined
- Q  output  WIDTH  register contents
- SOUT  output  1  serial output, combinational
- COUNT  output  CW  number of shifts since the last load or clear, saturating at WIDTH
- DONE  output  1  high while COUNT == WIDTH

## Operation
- Priority, highest first: RESET, CLEAR, ENABLE=0, MODE.
- RESET=1, asynchronous:
  - Q = RESET_VALUE, COUNT = 0, DONE = 0 immediately, without waiting for a clock edge.
  - State holds while RESET stays high.
- CLEAR=1 at an edge: Q <= 0, COUNT <= 0. This applies regardless of ENABLE and MODE.
- ENABLE=0 at an edge: Q and COUNT are unchanged.
- MODE 00 (hold): Q and COUNT are unchanged.
- MODE 01 (load): Q <= D, COUNT <= 0.
- MODE 10 (shift left): Q <= {Q[WIDTH-2:0], SIN}.
- MODE 11 (shift right): Q <= {SIN, Q[WIDTH-1:1]}.
- Counter:
  - Each shift edge (MODE 1x, ENABLE=1, CLEAR=0) sets COUNT <= COUNT+1 if COUNT < WIDTH; otherwise COUNT holds at WIDTH (saturates, no wrap).
- Outputs:
  - DONE = (COUNT == WIDTH), decoded from the registered count. It stays high until the next load, CLEAR or RESET.
  - SOUT = Q[0] when MODE == 11; otherwise SOUT = Q[WIDTH-1]. This is the bit that the next shift in the current direction discards.
- Counter state machine, implicit in COUNT:
  - IDLE (0), SHIFTING (1..WIDTH-1), FULL (WIDTH).
  - Load or clear returns to IDLE from any state.

## Timing
- Load and shift take effect one cycle after the sampling edge: Q updates at that edge.
- COUNT and DONE update at the same edge as Q. DONE rises on the edge that completes the WIDTH-th shift.
- SOUT is combinational: it follows Q and MODE in the same cycle.
- RESET asserted mid-shift: Q, COUNT and DONE go to their reset values asynchronously. The first edge after RESET deasserts is processed normally.
- CLEAR and load in the same cycle: CLEAR wins, so Q = 0, not D.
- Changing MODE between shift directions does not reset COUNT.

## Configuration
- Macro ROTATE_EN.
- Defined: in shift modes, ROTATE=1 replaces SIN with the outgoing bit.
  - Left rotate: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - Right rotate: Q <= {Q[0], Q[WIDTH-1:1]}.
  - Rotations count as shifts for COUNT and DONE.
- Undefined: the ROTATE port exists but is ignored, and all shifts use SIN.

## Test plan
All scenarios use WIDTH=8.
- Reset: assert RESET between clock edges with RESET_VALUE=8'h3C -> Q=8'h3C, COUNT=0, DONE=0 before the next edge.
- Load then shift left: load 8'hA5, then one shift left with SIN=1 -> Q=8'h4B, COUNT=1, SOUT=0.
- Shift right and hold: load 8'hA5, one shift right with SIN=0 -> Q=8'h52, SOUT=0. Then ENABLE=0 for 3 cycles -> Q stays 8'h52.
- Full-word shift: load 8'hFF, then 8 left shifts with SIN=0 -> Q=8'h00, COUNT=8, DONE=1. A 9th shift -> COUNT stays 8. A following load -> DONE=0.
- CLEAR priority: CLEAR=1 together with MODE=01 and D=8'h77 -> Q=8'h00, COUNT=0. Separately, assert RESET after 4 of 8 shifts -> Q=RESET_VALUE and COUNT=0 at once.
- ROTATE_EN defined: load 8'h81, rotate left -> Q=8'h03. Then rotate right twice -> Q=8'hC0, COUNT=3.

Source files
------------

// File: rtl/registro_deslocamento.sv
`default_nettype none
// ============================================================================
// Module   : registro_deslocamento
// Purpose  : WIDTH-bit multi-mode register (hold / parallel load / shift
//            left / shift right) with serial in/out, synchronous clear and a
//            saturating shift counter that flags a full-word shift.
// Ports    : CLOCK, RESET (async, active-high), ENABLE, CLEAR (sync),
//            MODE[1:0] (00 hold, 01 load, 10 shl, 11 shr), D[WIDTH-1:0],
//            SIN, ROTATE -> Q[WIDTH-1:0], SOUT, COUNT[CW-1:0], DONE
// Config   : define ROTATE_EN to let ROTATE=1 recirculate the outgoing bit
//            instead of SIN during shifts; otherwise ROTATE is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module registro_deslocamento #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              CW          = $clog2(WIDTH + 1)
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             CLEAR,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN,
  input  logic             ROTATE,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT,
  output logic [CW-1:0]    COUNT,
  output logic             DONE
);

  localparam logic [1:0]    c_MODE_HOLD  = 2'b00;
  localparam logic [1:0]    c_MODE_LOAD  = 2'b01;
  localparam logic [1:0]    c_MODE_SHL   = 2'b10;
  localparam logic [1:0]    c_MODE_SHR   = 2'b11;
  localparam logic [CW-1:0] c_COUNT_FULL = CW'(WIDTH);

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_count;
  logic             w_fill_left;
  logic             w_fill_right;
  logic             w_count_full;

  // Bit entering the register on each shift direction.
`ifdef ROTATE_EN
  assign w_fill_left  = ROTATE ? r_q[WIDTH-1] : SIN;
  assign w_fill_right = ROTATE ? r_q[0]       : SIN;
`else
  logic w_unused_rotate;
  assign w_unused_rotate = ROTATE;
  assign w_fill_left     = SIN;
  assign w_fill_right    = SIN;
`endif

  assign w_count_full = (r_count == c_COUNT_FULL);

  // Counter states are implicit in r_count: 0 idle, 1..WIDTH-1 shifting,
  // WIDTH full. Load/clear return it to idle; shifts saturate at full.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_q     <= RESET_VALUE;
      r_count <= '0;
    end else if (CLEAR) begin
      r_q     <= '0;
      r_count <= '0;
    end else if (ENABLE) begin
      case (MODE)
        c_MODE_HOLD: begin
          r_q     <= r_q;
          r_count <= r_count;
        end
        c_MODE_LOAD: begin
          r_q     <= D;
          r_count <= '0;
        end
        c_MODE_SHL: begin
          r_q <= {r_q[WIDTH-2:0], w_fill_left};
          if (!w_count_full) r_count <= r_count + CW'(1);
        end
        c_MODE_SHR: begin
          r_q <= {w_fill_right, r_q[WIDTH-1:1]};
          if (!w_count_full) r_count <= r_count + CW'(1);
        end
        default: begin
          r_q     <= r_q;
          r_count <= r_count;
        end
      endcase
    end
  end

  // SOUT is the bit the next shift in the selected direction would discard.
  assign SOUT  = (MODE == c_MODE_SHR) ? r_q[0] : r_q[WIDTH-1];
  assign Q     = r_q;
  assign COUNT = r_count;
  assign DONE  = w_count_full;

endmodule
`default_nettype wire

// File: tb/tb_registro_deslocamento.sv
`default_nettype none
// ============================================================================
// Module   : tb_registro_deslocamento
// Purpose  : Directed self-checking bench for registro_deslocamento with
//            WIDTH=8, RESET_VALUE=8'h3C. Rotation checks follow ROTATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_registro_deslocamento;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       clear;
  logic [1:0] mode;
  logic [7:0] d;
  logic       sin;
  logic       rotate;
  logic [7:0] q;
  logic       sout;
  logic [3:0] count;
  logic       done;

  int checks   = 0;
  int failures = 0;

  registro_deslocamento #(
    .WIDTH       (8),
    .RESET_VALUE (8'h3C)
  ) dut (
    .CLOCK  (clk),
    .RESET  (rst),
    .ENABLE (enable),
    .CLEAR  (clear),
    .MODE   (mode),
    .D      (d),
    .SIN    (sin),
    .ROTATE (rotate),
    .Q      (q),
    .SOUT   (sout),
    .COUNT  (count),
    .DONE   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Apply one set of inputs across a rising edge; returns 1 time unit after it.
  task automatic drive(input logic en, input logic clr, input logic [1:0] m,
                       input logic [7:0] dd, input logic s, input logic r);
    enable = en; clear = clr; mode = m; d = dd; sin = s; rotate = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b0, 2'b01, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'b10, 8'h00, 1'b1, 1'b0);
    checks++;
    if (q !== 8'h23 || count !== 4'd1) begin
      failures++;
      $display("FAIL reset_pre: q=%h count=%0d expected q=23 count=1", q, count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (q !== 8'h3C || count !== 4'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: q=%h count=%0d done=%b expected q=3c count=0 done=0", q, count, done);
    end
    drive(1'b1, 1'b0, 2'b01, 8'hEE, 1'b0, 1'b0);
    checks++;
    if (q !== 8'h3C) begin
      failures++;
      $display("FAIL reset_hold: q=%h expected 3c", q);
    end
    #2 rst = 1'b0;
    drive(1'b1, 1'b0, 2'b01, 8'hEE, 1'b0, 1'b0);
    checks++;
    if (q !== 8'hEE) begin
      failures++;
      $display("FAIL reset_release: q=%h expected ee", q);
    end
  endtask

  task automatic test_load_shift_left;
    drive(1'b1, 1'b0, 2'b01, 8'hA5, 1'b0, 1'b0);
    checks++;
    if (q !== 8'hA5 || count !== 4'd0) begin
      failures++;
      $display("FAIL load: q=%h count=%0d expected q=a5 count=0", q, count);
    end
    drive(1'b1, 1'b0, 2'b10, 8'h00, 1'b1, 1'b0);
    checks++;
    if (q !== 8'h4B || count !== 4'd1 || sout !== 1'b0) begin
      failures++;
      $display("FAIL shl: q=%h count=%0d sout=%b expected q=4b count=1 sout=0", q, count, sout);
    end
    // SOUT follows MODE combinationally: Q[0]=1 for right, Q[7]=0 for left.
    enable = 1'b0; mode = 2'b11;
    #1;
    checks++;
    if (sout !== 1'b1) begin
      failures++;
      $display("FAIL sout_right: sout=%b expected 1", sout);
    end
    mode = 2'b10;
    #1;
    checks++;
    if (sout !== 1'b0) begin
      failures++;
      $display("FAIL sout_left: sout=%b expected 0", sout);
    end
  endtask

  task automatic test_shift_right_hold;
    drive(1'b1, 1'b0, 2'b01, 8'hA5, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0);
    checks++;
    if (q !== 8'h52 || sout !== 1'b0 || count !== 4'd1) begin
      failures++;
      $display("FAIL shr: q=%h sout=%b count=%0d expected q=52 sout=0 count=1", q, sout, count);
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 2'b11, 8'hFF, 1'b1, 1'b0);
    checks++;
    if (q !== 8'h52 || count !== 4'd1) begin
      failures++;
      $display("FAIL enable_hold: q=%h count=%0d expected q=52 count=1", q, count);
    end
    drive(1'b1, 1'b0, 2'b00, 8'hFF, 1'b1, 1'b0);
    checks++;
    if (q !== 8'h52 || count !== 4'd1) begin
      failures++;
      $display("FAIL mode_hold: q=%h count=%0d expected q=52 count=1", q, count);
    end
  endtask

  task automatic test_full_word;
    drive(1'b1, 1'b0, 2'b01, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0);
    checks++;
    if (q !== 8'h80 || count !== 4'd7 || done !== 1'b0) begin
      failures++;
      $display("FAIL full_7: q=%h count=%0d done=%b expected q=80 count=7 done=0", q, count, done);
    end
    drive(1'b1, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0);
    checks++;
    if (q !== 8'h00 || count !== 4'd8 || done !== 1'b1) begin
      failures++;
      $display("FAIL full_8: q=%h count=%0d done=%b expected q=00 count=8 done=1", q, count, done);
    end
    drive(1'b1, 1'b0, 2'b10, 8'h00, 1'b1, 1'b0);
    checks++;
    if (q !== 8'h01 || count !== 4'd8 || done !== 1'b1) begin
      failures++;
      $display("FAIL full_sat: q=%h count=%0d done=%b expected q=01 count=8 done=1", q, count, done);
    end
    drive(1'b1, 1'b0, 2'b01, 8'h5A, 1'b0, 1'b0);
    checks++;
    if (q !== 8'h5A || count !== 4'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL full_reload: q=%h count=%0d done=%b expected q=5a count=0 done=0", q, count, done);
    end
  endtask

  task automatic test_direction_change;
    drive(1'b1, 1'b0, 2'b01, 8'h0F, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'b10, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 8'h00, 1'b1, 1'b0);
    checks++;
    if (q !== 8'h9E || count !== 4'd3) begin
      failures++;
      $display("FAIL dir_change: q=%h count=%0d expected q=9e count=3", q, count);
    end
  endtask

  task automatic test_clear_priority;
    drive(1'b1, 1'b0, 2'b01, 8'h33, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'b10, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 2'b01, 8'h77, 1'b0, 1'b0);
    checks++;
    if (q !== 8'h00 || count !== 4'd0) begin
      failures++;
      $display("FAIL clear_load: q=%h count=%0d expected q=00 count=0", q, count);
    end
    drive(1'b1, 1'b0, 2'b01, 8'h33, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'b10, 8'h00, 1'b1, 1'b0);
    checks++;
    if (q !== 8'h00) begin
      failures++;
      $display("FAIL clear_disabled: q=%h expected 00", q);
    end
  endtask

  task automatic test_reset_mid_shift;
    drive(1'b1, 1'b0, 2'b01, 8'hF0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 2'b11, 8'h00, 1'b1, 1'b0);
    checks++;
    if (q !== 8'hFF || count !== 4'd4) begin
      failures++;
      $display("FAIL mid_pre: q=%h count=%0d expected q=ff count=4", q, count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (q !== 8'h3C || count !== 4'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: q=%h count=%0d done=%b expected q=3c count=0 done=0", q, count, done);
    end
    #2 rst = 1'b0;
    drive(1'b1, 1'b0, 2'b11, 8'h00, 1'b1, 1'b0);
    checks++;
    if (q !== 8'h9E || count !== 4'd1) begin
      failures++;
      $display("FAIL mid_after: q=%h count=%0d expected q=9e count=1", q, count);
    end
  endtask

`ifdef ROTATE_EN
  task automatic test_rotate;
    drive(1'b1, 1'b0, 2'b01, 8'h81, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'b10, 8'h00, 1'b0, 1'b1);
    checks++;
    if (q !== 8'h03 || count !== 4'd1) begin
      failures++;
      $display("FAIL rotl: q=%h count=%0d expected q=03 count=1", q, count);
    end
    drive(1'b1, 1'b0, 2'b11, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 2'b11, 8'h00, 1'b0, 1'b1);
    checks++;
    if (q !== 8'hC0 || count !== 4'd3) begin
      failures++;
      $display("FAIL rotr: q=%h count=%0d expected q=c0 count=3", q, count);
    end
  endtask
`else
  task automatic test_rotate;
    drive(1'b1, 1'b0, 2'b01, 8'h81, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'b10, 8'h00, 1'b0, 1'b1);
    checks++;
    if (q !== 8'h02 || count !== 4'd1) begin
      failures++;
      $display("FAIL rot_ignored_l: q=%h count=%0d expected q=02 count=1", q, count);
    end
    drive(1'b1, 1'b0, 2'b11, 8'h00, 1'b1, 1'b1);
    checks++;
    if (q !== 8'h81 || count !== 4'd2) begin
      failures++;
      $display("FAIL rot_ignored_r: q=%h count=%0d expected q=81 count=2", q, count);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; enable = 1'b0; clear = 1'b0; mode = 2'b00;
    d = 8'h00; sin = 1'b0; rotate = 1'b0;
    #1;
    checks++;
    if (q !== 8'h3C || count !== 4'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL power_on_reset: q=%h count=%0d done=%b expected q=3c count=0 done=0", q, count, done);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    test_reset();
    test_load_shift_left();
    test_shift_right_hold();
    test_full_word();
    test_direction_change();
    test_clear_priority();
    test_reset_mid_shift();
    test_rotate();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
